// File: rtl/nim_turn_controller.sv
// Turn sequencer for the two-player matchstick game: synchronizes scanner key events,
// validates moves, alternates players and drives the seven-segment display word.
module nim_turn_controller #(
  parameter int         TOTAL_W    = 16,
  parameter int         MAX_TAKE   = 3,
  parameter logic [3:0] KEY_START  = 4'hE,
  parameter logic [3:0] KEY_COMMIT = 4'hF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_ready,
  input  logic [3:0]         key_code,
  output logic               key_ack,
  output logic [TOTAL_W-1:0] disp_data,
  output logic               player,
  output logic [3:0]         pending_take,
  output logic               game_over,
  output logic               winner,
  output logic               err
);

  typedef enum logic [1:0] {
    ST_ENTRY  = 2'd0,
    ST_P_TURN = 2'd1,
    ST_OVER   = 2'd2
  } state_t;

  localparam logic [3:0]         MAX_KEY  = 4'(MAX_TAKE);
  localparam logic [TOTAL_W-1:0] DISP_P1  = TOTAL_W'(1);
  localparam logic [TOTAL_W-1:0] DISP_P2  = TOTAL_W'(2);

  state_t             state_reg, state_next;
  logic [2:0]         sync_reg;
  logic [TOTAL_W-1:0] entry_reg, entry_next;
  logic [TOTAL_W-1:0] total_reg, total_next;
  logic [3:0]         pending_reg, pending_next;
  logic               player_reg, player_next;
  logic               winner_reg, winner_next;
  logic               err_reg, err_next;
  logic               ack_reg, ack_next;
  logic               over_reg, over_next;
  logic [TOTAL_W-1:0] disp_reg, disp_next;

  logic               key_event;
  logic               key_is_digit;
  logic [TOTAL_W-1:0] pending_ext;
  logic [TOTAL_W-1:0] total_after;

  // sync_reg[1:0] is the two-flop synchronizer, sync_reg[2] remembers the previous synced level
  assign key_event    = sync_reg[1] & ~sync_reg[2];
  assign key_is_digit = (key_code != KEY_START) && (key_code != KEY_COMMIT);
  assign pending_ext  = {{(TOTAL_W-4){1'b0}}, pending_reg};
  assign total_after  = total_reg - pending_ext;

  always_comb begin
    state_next   = state_reg;
    entry_next   = entry_reg;
    total_next   = total_reg;
    pending_next = pending_reg;
    player_next  = player_reg;
    winner_next  = winner_reg;
    err_next     = err_reg;
    ack_next     = key_event;
    disp_next    = disp_reg;

    if (key_event) begin
      case (state_reg)
        ST_ENTRY: begin
          if (key_is_digit) begin
            entry_next = {entry_reg[TOTAL_W-5:0], key_code};
            err_next   = 1'b0;
          end else if (key_code == KEY_START && entry_reg != '0) begin
            total_next   = entry_reg;
            player_next  = 1'b0;
            pending_next = 4'd0;
            err_next     = 1'b0;
            state_next   = ST_P_TURN;
          end else begin
            err_next = 1'b1;
          end
        end
        ST_P_TURN: begin
          if (key_code == KEY_COMMIT) begin
            // A commit that would overdraw the pile is rejected, so total never wraps
            if (pending_reg == 4'd0 || pending_ext > total_reg) begin
              err_next = 1'b1;
            end else begin
              total_next   = total_after;
              pending_next = 4'd0;
              err_next     = 1'b0;
              if (total_after == '0) begin
                state_next  = ST_OVER;
                winner_next = ~player_reg;
              end else begin
                player_next = ~player_reg;
              end
            end
          end else if (key_code != 4'd0 && key_code <= MAX_KEY) begin
            pending_next = key_code;
            err_next     = 1'b0;
          end else begin
            err_next = 1'b1;
          end
        end
        ST_OVER: begin
          if (key_code == KEY_START) begin
            entry_next = '0;
            total_next = '0;
            err_next   = 1'b0;
            state_next = ST_ENTRY;
          end
        end
        default: state_next = ST_ENTRY;
      endcase
    end

    case (state_next)
      ST_ENTRY:  disp_next = entry_next;
      ST_P_TURN: disp_next = total_next;
      ST_OVER:   disp_next = winner_next ? DISP_P2 : DISP_P1;
      default:   disp_next = '0;
    endcase
    over_next = (state_next == ST_OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_ENTRY;
      sync_reg    <= 3'b000;
      entry_reg   <= '0;
      total_reg   <= '0;
      pending_reg <= 4'd0;
      player_reg  <= 1'b0;
      winner_reg  <= 1'b0;
      err_reg     <= 1'b0;
      ack_reg     <= 1'b0;
      over_reg    <= 1'b0;
      disp_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      sync_reg    <= {sync_reg[1:0], key_ready};
      entry_reg   <= entry_next;
      total_reg   <= total_next;
      pending_reg <= pending_next;
      player_reg  <= player_next;
      winner_reg  <= winner_next;
      err_reg     <= err_next;
      ack_reg     <= ack_next;
      over_reg    <= over_next;
      disp_reg    <= disp_next;
    end
  end

  assign key_ack      = ack_reg;
  assign disp_data    = disp_reg;
  assign player       = player_reg;
  assign pending_take = pending_reg;
  assign game_over    = over_reg;
  assign winner       = winner_reg;
  assign err          = err_reg;

endmodule
